// File: rtl/fft_result_writeback.sv
// Write-back stage for the long-range FFT memory controller: buffers parallel
// FFT result beats, attaches per-lane grid addresses and writes them to memory.
module fft_result_writeback #(
  parameter int DIMENSION       = 16,
  parameter int NUM_FFTS        = 4,
  parameter int DATA_REAL_WIDTH = 32,
  parameter int DATA_IMAG_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [2:0]                              FFT_dim,
  input  logic                                    scale_en,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NUM_FFTS*(DATA_REAL_WIDTH+1)-1:0] in_real,
  input  logic [NUM_FFTS*(DATA_IMAG_WIDTH+1)-1:0] in_imag,
  input  logic                                    mem_grant,
  output logic                                    wr_en,
  output logic [NUM_FFTS*3*$clog2(DIMENSION)-1:0] wr_addr,
  output logic [NUM_FFTS*(DATA_REAL_WIDTH+1)-1:0] wr_real,
  output logic [NUM_FFTS*(DATA_IMAG_WIDTH+1)-1:0] wr_imag,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    dim_err
);

  localparam int LOG2D  = $clog2(DIMENSION);
  localparam int ADDR_W = 3 * LOG2D;
  localparam int RW     = DATA_REAL_WIDTH + 1;
  localparam int IW     = DATA_IMAG_WIDTH + 1;
  localparam int GROUPS = DIMENSION * DIMENSION / NUM_FFTS;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LW     = 2 * LOG2D;
  localparam int DEPTH  = 4;
  localparam int AV     = NUM_FFTS * ADDR_W;
  localparam int RV     = NUM_FFTS * RW;
  localparam int IV     = NUM_FFTS * IW;

  localparam logic [LOG2D-1:0] K_LAST = LOG2D'(DIMENSION - 1);
  localparam logic [GW-1:0]    G_LAST = GW'(GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic logic [RW-1:0] scale_real(input logic [RW-1:0] v, input logic en);
    logic signed [RW-1:0] s;
    s = v;
    s = s >>> LOG2D;
    return en ? $unsigned(s) : v;
  endfunction

  function automatic logic [IW-1:0] scale_imag(input logic [IW-1:0] v, input logic en);
    logic signed [IW-1:0] s;
    s = v;
    s = s >>> LOG2D;
    return en ? $unsigned(s) : v;
  endfunction

  // Line l = g*NUM_FFTS + lane splits into a (fast) and b (slow); the pass
  // direction decides which grid axis the sample index k walks along.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [2:0]       dim,
                                                  input logic [GW-1:0]    g,
                                                  input logic [LOG2D-1:0] k,
                                                  input int               lane);
    logic [LW-1:0]    l;
    logic [LOG2D-1:0] a;
    logic [LOG2D-1:0] b;
    l = LW'(int'(g) * NUM_FFTS + lane);
    a = l[LOG2D-1:0];
    b = l[LW-1:LOG2D];
    case (dim)
      3'b001:  lane_addr = {b, a, k};
      3'b010:  lane_addr = {b, k, a};
      default: lane_addr = {k, b, a};
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [LOG2D-1:0] k_q, k_d;
  logic [GW-1:0]    g_q, g_d;
  logic [2:0]       dim_q, dim_d;
  logic             scale_q, scale_d;
  logic [1:0]       wptr_q, wptr_d;
  logic [1:0]       rptr_q, rptr_d;
  logic [2:0]       count_q, count_d;
  logic             out_vld_q, out_vld_d;
  logic [AV-1:0]    wr_addr_q, wr_addr_d;
  logic [RV-1:0]    wr_real_q, wr_real_d;
  logic [IV-1:0]    wr_imag_q, wr_imag_d;
  logic             done_q, done_d;
  logic             dim_err_q, dim_err_d;

  logic [AV-1:0]    fifo_addr_q [DEPTH];
  logic [RV-1:0]    fifo_real_q [DEPTH];
  logic [IV-1:0]    fifo_imag_q [DEPTH];

  logic [AV-1:0]    push_addr;
  logic [RV-1:0]    push_real;
  logic [IV-1:0]    push_imag;

  logic dim_ok;
  logic start_ok;
  logic accept;
  logic pop;
  logic last_beat;
  logic drain_empty;

  assign dim_ok      = (FFT_dim == 3'b001) || (FFT_dim == 3'b010) || (FFT_dim == 3'b100);
  assign start_ok    = (state_q == S_IDLE) && start && dim_ok;
  assign accept      = in_valid && in_ready;
  assign last_beat   = (k_q == K_LAST) && (g_q == G_LAST);
  assign pop         = (count_q != 3'd0) && (!out_vld_q || mem_grant);
  assign drain_empty = (count_q == 3'd0) && (!out_vld_q || mem_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (accept && last_beat) state_d = S_DRAIN;
      S_DRAIN: if (drain_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered on the edge that retires the final write, so it
  // appears in the same cycle busy drops.
  always_comb begin
    in_ready  = (state_q == S_RUN) && (count_q < 3'(DEPTH));
    busy      = (state_q != S_IDLE);
    done_d    = (state_q == S_DRAIN) && drain_empty;
    dim_err_d = (state_q == S_IDLE) && start && !dim_ok;
  end

  always_comb begin
    k_d     = k_q;
    g_d     = g_q;
    dim_d   = dim_q;
    scale_d = scale_q;
    if (start_ok) begin
      k_d     = '0;
      g_d     = '0;
      dim_d   = FFT_dim;
      scale_d = scale_en;
    end else if (accept) begin
      if (k_q == K_LAST) begin
        k_d = '0;
        g_d = g_q + 1'b1;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_comb begin
    push_addr = '0;
    push_real = '0;
    push_imag = '0;
    for (int i = 0; i < NUM_FFTS; i++) begin
      push_addr[i*ADDR_W +: ADDR_W] = lane_addr(dim_q, g_q, k_q, i);
      push_real[i*RW +: RW]         = scale_real(in_real[i*RW +: RW], scale_q);
      push_imag[i*IW +: IW]         = scale_imag(in_imag[i*IW +: IW], scale_q);
    end
  end

  always_comb begin
    wptr_d  = accept ? wptr_q + 2'd1 : wptr_q;
    rptr_d  = pop ? rptr_q + 2'd1 : rptr_q;
    count_d = count_q + 3'(accept) - 3'(pop);
  end

  // Output register refills from the FIFO head whenever it is empty or being
  // retired by a grant; otherwise it holds for the arbiter.
  always_comb begin
    out_vld_d = out_vld_q;
    wr_addr_d = wr_addr_q;
    wr_real_d = wr_real_q;
    wr_imag_d = wr_imag_q;
    if (pop) begin
      out_vld_d = 1'b1;
      wr_addr_d = fifo_addr_q[rptr_q];
      wr_real_d = fifo_real_q[rptr_q];
      wr_imag_d = fifo_imag_q[rptr_q];
    end else if (out_vld_q && mem_grant) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q       <= '0;
      g_q       <= '0;
      dim_q     <= 3'b001;
      scale_q   <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      wr_addr_q <= '0;
      wr_real_q <= '0;
      wr_imag_q <= '0;
      done_q    <= 1'b0;
      dim_err_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      g_q       <= g_d;
      dim_q     <= dim_d;
      scale_q   <= scale_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_real_q <= wr_real_d;
      wr_imag_q <= wr_imag_d;
      done_q    <= done_d;
      dim_err_q <= dim_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_addr_q[wptr_q] <= push_addr;
      fifo_real_q[wptr_q] <= push_real;
      fifo_imag_q[wptr_q] <= push_imag;
    end
  end

  assign wr_en   = out_vld_q;
  assign wr_addr = wr_addr_q;
  assign wr_real = wr_real_q;
  assign wr_imag = wr_imag_q;
  assign done    = done_q;
  assign dim_err = dim_err_q;

endmodule
